// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage: shift-add multiply, restoring divide, one bit per cycle.
// Optional EX_SINGLE_CYCLE_MUL_EN: MULT/MULTU use the combinational '*' and finish one edge after accept.
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             start,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             Flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             op_mul;
    logic             sign_a;
    logic             sign_b;
    logic             zero_div;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] work_hi;
    logic [WIDTH-1:0] work_lo;

    function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] v);
        return n ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg2_if(input logic n, input logic [2*WIDTH-1:0] v);
        return n ? -v : v;
    endfunction

    // Decode and operand magnitudes at the accept edge
    logic             funct_ok;
    logic             is_mul_in;
    logic             is_signed_in;
    logic             sa_in;
    logic             sb_in;
    logic [WIDTH-1:0] a_mag_in;
    logic [WIDTH-1:0] b_mag_in;
    logic             accept;
    logic             div_zero_in;

    assign funct_ok     = (Funct[5:2] == 4'b0110);
    assign is_mul_in    = ~Funct[1];
    assign is_signed_in = ~Funct[0];
    assign sa_in        = is_signed_in & SrcA[WIDTH-1];
    assign sb_in        = is_signed_in & SrcB[WIDTH-1];
    assign a_mag_in     = neg_if(sa_in, SrcA);
    assign b_mag_in     = neg_if(sb_in, SrcB);
    assign accept       = (state == S_IDLE) && start && funct_ok && !Flush;
    assign div_zero_in  = !is_mul_in && (SrcB == '0);

    // One iteration of each datapath; {work_hi, work_lo} is the product or {remainder, quotient}
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;

    assign mul_sum   = {1'b0, work_hi} + {1'b0, a_reg & {WIDTH{work_lo[0]}}};
    assign div_shift = {work_hi, work_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_reg};
    assign div_ge    = ~div_diff[WIDTH];

    always_ff @(posedge CLOCK) begin
        if (accept) begin
            a_reg   <= a_mag_in;
            b_reg   <= b_mag_in;
            work_hi <= '0;
            work_lo <= is_mul_in ? b_mag_in : a_mag_in;
        end else if (state == S_MUL) begin
            {work_hi, work_lo} <= {mul_sum, work_lo[WIDTH-1:1]};
        end else if (state == S_DIV) begin
            work_hi <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            work_lo <= {work_lo[WIDTH-2:0], div_ge};
        end
    end

    // Sign correction applied when writing results
    logic [2*WIDTH-1:0] mul_mag;
    logic [2*WIDTH-1:0] mul_res;
    logic [WIDTH-1:0]   q_res;
    logic [WIDTH-1:0]   r_res;
    logic [WIDTH-1:0]   a_raw;

`ifdef EX_SINGLE_CYCLE_MUL_EN
    assign mul_mag = {{WIDTH{1'b0}}, a_reg} * {{WIDTH{1'b0}}, b_reg};
`else
    assign mul_mag = {work_hi, work_lo};
`endif

    assign mul_res = neg2_if(sign_a ^ sign_b, mul_mag);
    assign q_res   = neg_if(sign_a ^ sign_b, work_lo);
    assign r_res   = neg_if(sign_a, work_hi);
    assign a_raw   = neg_if(sign_a, a_reg);

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state       <= S_IDLE;
            cnt         <= '0;
            op_mul      <= 1'b0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            zero_div    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_mul      <= is_mul_in;
                        sign_a      <= sa_in;
                        sign_b      <= sb_in;
                        zero_div    <= div_zero_in;
                        cnt         <= '0;
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        if (div_zero_in) begin
                            state <= S_FIX;
                        end else if (is_mul_in) begin
`ifdef EX_SINGLE_CYCLE_MUL_EN
                            state <= S_FIX;
`else
                            state <= S_MUL;
`endif
                        end else begin
                            state <= S_DIV;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (Flush) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    if (!Flush) begin
                        done <= 1'b1;
                        if (zero_div) begin
                            hi          <= a_raw;
                            lo          <= '1;
                            div_by_zero <= 1'b1;
                        end else if (op_mul) begin
                            {hi, lo} <= mul_res;
                        end else begin
                            hi <= r_res;
                            lo <= q_res;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed vector table, hand-written corner sequences, random ops vs. a 64-bit arithmetic model.
module tb_ex_muldiv_unit;

    logic        CLOCK;
    logic        RESET;
    logic        start;
    logic [5:0]  Funct;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int n_cmp = 0;
    int n_fail = 0;

`ifdef EX_SINGLE_CYCLE_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .start(start), .Funct(Funct),
        .SrcA(SrcA), .SrcB(SrcB), .Flush(Flush), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
        logic        edbz;
        int          elat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero
    task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] ehi, output logic [31:0] elo,
                         output logic edbz, output int elat);
        longint sa, sb, p;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        edbz = 1'b0;
        ehi = '0;
        elo = '0;
        elat = DIV_LAT;
        if (f == 6'h18) begin
            p = sa * sb;
            {ehi, elo} = p;
            elat = MUL_LAT;
        end else if (f == 6'h19) begin
            up = {32'b0, a} * {32'b0, b};
            {ehi, elo} = up;
            elat = MUL_LAT;
        end else if (b == 32'b0) begin
            ehi = a;
            elo = 32'hFFFF_FFFF;
            edbz = 1'b1;
            elat = 1;
        end else if (f == 6'h1A) begin
            p = sa / sb;
            elo = p[31:0];
            p = sa % sb;
            ehi = p[31:0];
        end else begin
            elo = a / b;
            ehi = a % b;
        end
    endtask

    // Issues one op from idle and checks latency, busy length, stability and results;
    // intr > 0 pulses an extra start at that edge of the operation.
    task automatic run_op(input string nm, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                          input int elat, input int intr);
        logic [31:0] hi0, lo0;
        int busy_cnt, lat;
        bit stable, seen;
        hi0 = hi;
        lo0 = lo;
        Funct = f;
        SrcA = a;
        SrcB = b;
        start = 1'b1;
        step();
        start = 1'b0;
        SrcA = $urandom;
        SrcB = $urandom;
        chk({nm, ":busy_at_accept"}, 32'(busy), 32'd1);
        chk({nm, ":dbz_cleared"}, 32'(div_by_zero), 32'd0);
        busy_cnt = busy ? 1 : 0;
        lat = 0;
        stable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            start = (intr > 0) && (lat + 1 == intr);
            if (start) Funct = 6'h1A;
            step();
            start = 1'b0;
            lat++;
            if (done) seen = 1'b1;
            else begin
                if (busy) busy_cnt++;
                if (hi !== hi0 || lo !== lo0) stable = 1'b0;
            end
        end
        chk({nm, ":done_seen"}, 32'(seen), 32'd1);
        chk({nm, ":latency"}, 32'(lat), 32'(elat));
        chk({nm, ":busy_cycles"}, 32'(busy_cnt), 32'(elat));
        chk({nm, ":stable"}, 32'(stable), 32'd1);
        chk({nm, ":hi"}, hi, ehi);
        chk({nm, ":lo"}, lo, elo);
        chk({nm, ":dbz"}, 32'(div_by_zero), 32'(edbz));
        chk({nm, ":busy_at_done"}, 32'(busy), 32'd0);
        step();
        chk({nm, ":done_pulse"}, 32'(done), 32'd0);
    endtask

    vec_t vt[9];

    initial begin
        logic [31:0] ehi, elo, hi0, lo0;
        logic edbz, dbz0;
        int elat;
        bit any_done;
        logic [5:0] rf;
        logic [31:0] ra, rb;

        vt[0] = '{6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, MUL_LAT};
        vt[1] = '{6'h18, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, MUL_LAT};
        vt[2] = '{6'h18, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, MUL_LAT};
        vt[3] = '{6'h1A, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, DIV_LAT};
        vt[4] = '{6'h1A, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, DIV_LAT};
        vt[5] = '{6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, DIV_LAT};
        vt[6] = '{6'h1B, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 1};
        vt[7] = '{6'h1B, 32'h0000_0009, 32'h0000_0004, 32'h0000_0001, 32'h0000_0002, 1'b0, DIV_LAT};
        vt[8] = '{6'h1A, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 1};

        RESET = 1'b1;
        start = 1'b0;
        Flush = 1'b0;
        Funct = 6'h00;
        SrcA = '0;
        SrcB = '0;
        repeat (2) @(posedge CLOCK);
        #1;
        chk("reset:busy", 32'(busy), 32'd0);
        chk("reset:done", 32'(done), 32'd0);
        chk("reset:hi", hi, 32'd0);
        chk("reset:lo", lo, 32'd0);
        chk("reset:dbz", 32'(div_by_zero), 32'd0);
        RESET = 1'b0;
        step();

        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), vt[i].f, vt[i].a, vt[i].b,
                   vt[i].ehi, vt[i].elo, vt[i].edbz, vt[i].elat, 0);
            if (i == 6) begin
                repeat (3) step();
                chk("dbz_held", 32'(div_by_zero), 32'd1);
            end
        end

        // Unknown function code is ignored
        hi0 = hi;
        Funct = 6'h20;
        SrcA = 32'h1234;
        SrcB = 32'h5;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("bad_funct:busy", 32'(busy), 32'd0);
        step();
        chk("bad_funct:done", 32'(done), 32'd0);
        chk("bad_funct:hi", hi, hi0);

        // Flush and start together in idle: start dropped
        Funct = 6'h19;
        start = 1'b1;
        Flush = 1'b1;
        step();
        start = 1'b0;
        Flush = 1'b0;
        chk("flush_start:busy", 32'(busy), 32'd0);
        step();
        chk("flush_start:done", 32'(done), 32'd0);

        // Start while busy is ignored
        model(6'h19, 32'hDEAD_BEEF, 32'h0BAD_F00D, ehi, elo, edbz, elat);
        run_op("start_busy", 6'h19, 32'hDEAD_BEEF, 32'h0BAD_F00D, ehi, elo, edbz, elat, 5);

        // Flush mid-division
        hi0 = hi;
        lo0 = lo;
        dbz0 = div_by_zero;
        Funct = 6'h1B;
        SrcA = 32'd100;
        SrcB = 32'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        chk("flush:busy", 32'(busy), 32'd0);
        any_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) any_done = 1'b1;
        end
        chk("flush:no_done", 32'(any_done), 32'd0);
        chk("flush:hi", hi, hi0);
        chk("flush:lo", lo, lo0);
        chk("flush:dbz", 32'(div_by_zero), 32'(dbz0));
        run_op("after_flush", 6'h1B, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, DIV_LAT, 0);

        // Asynchronous reset mid-division, after a divide-by-zero left every output nonzero
        run_op("pre_reset", 6'h1B, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 1, 0);
        Funct = 6'h1A;
        SrcA = 32'h0001_0000;
        SrcB = 32'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (12) step();
        #2;
        RESET = 1'b1;
        #1;
        chk("async_reset:busy", 32'(busy), 32'd0);
        chk("async_reset:hi", hi, 32'd0);
        chk("async_reset:lo", lo, 32'd0);
        chk("async_reset:dbz", 32'(div_by_zero), 32'd0);
        #1;
        RESET = 1'b0;
        any_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done || busy) any_done = 1'b1;
        end
        chk("async_reset:no_done", 32'(any_done), 32'd0);

        // Random operations against the model
        for (int i = 0; i < 150; i++) begin
            rf = 6'h18 + 6'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0: ra = 32'h8000_0000;
                1: ra = 32'($urandom_range(0, 20));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 9))
                0: rb = 32'h0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            model(rf, ra, rb, ehi, elo, edbz, elat);
            run_op($sformatf("rnd%0d_f%h_%h_%h", i, rf, ra, rb), rf, ra, rb, ehi, elo, edbz, elat, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
